// File: rtl/if_id_stall_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : if_id_stall_ctrl_if                                        |
// | Brief    : Fetch/decode boundary bus for the IF/ID stall controller.  |
// |            stall_count exists only when STALL_STATS_EN is defined.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface if_id_stall_ctrl_if #(
  parameter int OPERAND_WIDTH = 16,
  parameter int CNT_WIDTH     = 16
);
  logic [OPERAND_WIDTH-1:0] instr_in;
  logic [OPERAND_WIDTH-1:0] pc_incr_in;
  logic                     fetch_valid;
  logic                     Stall;
  logic                     flush;
  logic [OPERAND_WIDTH-1:0] instr_out;
  logic [OPERAND_WIDTH-1:0] pc_incr_out;
  logic                     valid_out;
  logic                     pc_we;
  logic                     id_ex_bubble;
  logic                     halted;
  logic                     stall_err;
`ifdef STALL_STATS_EN
  logic [CNT_WIDTH-1:0]     stall_count;
`endif

  modport master (
    output instr_in, pc_incr_in, fetch_valid, Stall, flush,
    input  instr_out, pc_incr_out, valid_out, pc_we, id_ex_bubble, halted, stall_err
`ifdef STALL_STATS_EN
    , input stall_count
`endif
  );

  modport slave (
    input  instr_in, pc_incr_in, fetch_valid, Stall, flush,
    output instr_out, pc_incr_out, valid_out, pc_we, id_ex_bubble, halted, stall_err
`ifdef STALL_STATS_EN
    , output stall_count
`endif
  );
endinterface
`default_nettype wire

// File: rtl/if_id_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : if_id_stall_ctrl                                           |
// | Brief    : IF/ID register owner: hold, squash, imem-miss bubble and   |
// |            HALT freeze. STALL_STATS_EN adds the stall_count counter.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module if_id_stall_ctrl #(
  parameter int                     OPERAND_WIDTH = 16,
  parameter logic [OPERAND_WIDTH-1:0] NOP_INSTR   = 16'h0800,
  parameter logic [4:0]             HALT_OPCODE   = 5'b00000,
  parameter int                     MAX_STALL     = 4,
  parameter int                     CNT_WIDTH     = 16
) (
  input  wire                 clk,
  input  wire                 rst,
  if_id_stall_ctrl_if.slave   bus
);
  localparam int RUN_W = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0] c_run_max = RUN_W'(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] c_run_lim = RUN_W'(MAX_STALL);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [OPERAND_WIDTH-1:0] instr_q, instr_d;
  logic [OPERAND_WIDTH-1:0] pc_incr_q, pc_incr_d;
  logic                     valid_q, valid_d;
  logic                     halted_q, halted_d;
  logic                     stall_err_q, stall_err_d;
  logic [RUN_W-1:0]         run_cnt_q, run_cnt_d;
  logic                     pc_we;
  logic                     id_ex_bubble;
  logic                     halt_in_id;

  assign halt_in_id = valid_q && (instr_q[OPERAND_WIDTH-1 -: 5] == HALT_OPCODE);

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    pc_incr_d    = pc_incr_q;
    valid_d      = valid_q;
    halted_d     = halted_q;
    stall_err_d  = stall_err_q;
    run_cnt_d    = '0;
    pc_we        = 1'b0;
    id_ex_bubble = 1'b1;
    if (rst) begin
      pc_we        = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (state_q == HALTED) begin
      instr_d  = NOP_INSTR;
      valid_d  = 1'b0;
      halted_d = 1'b1;
    end else if (bus.flush) begin
      pc_we   = 1'b1;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (bus.Stall) begin
      state_d   = HOLD;
      run_cnt_d = (run_cnt_q == c_run_max) ? run_cnt_q : run_cnt_q + RUN_W'(1);
      if (run_cnt_d > c_run_lim) begin
        stall_err_d = 1'b1;
      end
    end else if (halt_in_id) begin
      // HALT moves on to ID/EX this edge; fetch is frozen from here on
      id_ex_bubble = 1'b0;
      instr_d      = NOP_INSTR;
      valid_d      = 1'b0;
      halted_d     = 1'b1;
      state_d      = HALTED;
    end else if (!bus.fetch_valid) begin
      id_ex_bubble = 1'b0;
      instr_d      = NOP_INSTR;
      valid_d      = 1'b0;
      state_d      = RUN;
    end else begin
      pc_we        = 1'b1;
      id_ex_bubble = 1'b0;
      instr_d      = bus.instr_in;
      pc_incr_d    = bus.pc_incr_in;
      valid_d      = 1'b1;
      state_d      = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      instr_q     <= NOP_INSTR;
      pc_incr_q   <= '0;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
      stall_err_q <= 1'b0;
      run_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      pc_incr_q   <= pc_incr_d;
      valid_q     <= valid_d;
      halted_q    <= halted_d;
      stall_err_q <= stall_err_d;
      run_cnt_q   <= run_cnt_d;
    end
  end

`ifdef STALL_STATS_EN
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (!rst && id_ex_bubble && (state_q != HALTED) && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.stall_count = stall_count_q;
`endif

  assign bus.instr_out    = instr_q;
  assign bus.pc_incr_out  = pc_incr_q;
  assign bus.valid_out    = valid_q;
  assign bus.halted       = halted_q;
  assign bus.stall_err    = stall_err_q;
  assign bus.pc_we        = pc_we;
  assign bus.id_ex_bubble = id_ex_bubble;
endmodule
`default_nettype wire

// File: tb/tb_if_id_stall_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_if_id_stall_ctrl                                        |
// | Brief    : Directed scoreboard bench for if_id_stall_ctrl.            |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_if_id_stall_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct {
    string       tag;
    logic [15:0] instr;
    logic [15:0] pc;
    logic        chk_pc;
    logic        valid;
    logic        halted;
    logic        err;
  } exp_t;

  exp_t sb[$];

  if_id_stall_ctrl_if #(.OPERAND_WIDTH(16), .CNT_WIDTH(16)) bus ();

  if_id_stall_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, then pop the
  // expected registered state after the following posedge.
  task automatic step(input string tag, input logic r, input logic fv,
                      input logic st, input logic fl,
                      input logic [15:0] ins, input logic [15:0] pc,
                      input logic chk_we, input logic e_we, input logic e_bub,
                      input logic [15:0] e_ins, input logic chk_pc,
                      input logic [15:0] e_pc, input logic e_val,
                      input logic e_halt, input logic e_err);
    exp_t e;
    @(negedge clk);
    rst             = r;
    bus.fetch_valid = fv;
    bus.Stall       = st;
    bus.flush       = fl;
    bus.instr_in    = ins;
    bus.pc_incr_in  = pc;
    #1;
    if (chk_we) chk({tag, ".pc_we"}, 32'(bus.pc_we), 32'(e_we));
    chk({tag, ".bubble"}, 32'(bus.id_ex_bubble), 32'(e_bub));
    e.tag = tag; e.instr = e_ins; e.pc = e_pc; e.chk_pc = chk_pc;
    e.valid = e_val; e.halted = e_halt; e.err = e_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_tests++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL %s.sb: observed empty expected entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".instr"}, 32'(bus.instr_out), 32'(e.instr));
      if (e.chk_pc) chk({e.tag, ".pc"}, 32'(bus.pc_incr_out), 32'(e.pc));
      chk({e.tag, ".valid"}, 32'(bus.valid_out), 32'(e.valid));
      chk({e.tag, ".halted"}, 32'(bus.halted), 32'(e.halted));
      chk({e.tag, ".err"}, 32'(bus.stall_err), 32'(e.err));
    end
  endtask

  initial begin
    bus.fetch_valid = 1'b0;
    bus.Stall       = 1'b0;
    bus.flush       = 1'b0;
    bus.instr_in    = 16'h0;
    bus.pc_incr_in  = 16'h0;

    //    tag       r  fv st fl ins       pc       cw we bub e_ins     cp e_pc     v  h  err
    step("reset",   1, 1, 0, 0, 16'h4101, 16'h0002, 1, 0, 1, 16'h0800, 1, 16'h0000, 0, 0, 0);
    step("fetch1",  0, 1, 0, 0, 16'h4101, 16'h0002, 1, 1, 0, 16'h4101, 1, 16'h0002, 1, 0, 0);
    step("fetch2",  0, 1, 0, 0, 16'h4202, 16'h0004, 1, 1, 0, 16'h4202, 1, 16'h0004, 1, 0, 0);
    step("fetch3",  0, 1, 0, 0, 16'h4303, 16'h0006, 1, 1, 0, 16'h4303, 1, 16'h0006, 1, 0, 0);
    step("fetch4",  0, 1, 0, 0, 16'h8120, 16'h0008, 1, 1, 0, 16'h8120, 1, 16'h0008, 1, 0, 0);
    step("stall1",  0, 1, 1, 0, 16'h9999, 16'h000a, 1, 0, 1, 16'h8120, 1, 16'h0008, 1, 0, 0);
    step("resume",  0, 1, 0, 0, 16'ha000, 16'h000a, 1, 1, 0, 16'ha000, 1, 16'h000a, 1, 0, 0);
    step("stfl",    0, 1, 1, 1, 16'hb000, 16'h000c, 1, 1, 1, 16'h0800, 0, 16'h0000, 0, 0, 0);
    step("miss1",   0, 0, 0, 0, 16'hc000, 16'h000e, 1, 0, 0, 16'h0800, 0, 16'h0000, 0, 0, 0);
    step("miss2",   0, 0, 0, 0, 16'hc000, 16'h000e, 1, 0, 0, 16'h0800, 0, 16'h0000, 0, 0, 0);
    step("ldhalt",  0, 1, 0, 0, 16'h0000, 16'h0010, 1, 1, 0, 16'h0000, 1, 16'h0010, 1, 0, 0);
    step("halt",    0, 1, 0, 0, 16'h5555, 16'h0012, 0, 0, 0, 16'h0800, 0, 16'h0000, 0, 1, 0);
    step("hflush",  0, 1, 0, 1, 16'h5555, 16'h0012, 1, 0, 1, 16'h0800, 0, 16'h0000, 0, 1, 0);
    step("hstall",  0, 1, 1, 0, 16'h5555, 16'h0012, 1, 0, 1, 16'h0800, 0, 16'h0000, 0, 1, 0);
    step("hrst",    1, 1, 0, 0, 16'h5555, 16'h0012, 1, 0, 1, 16'h0800, 1, 16'h0000, 0, 0, 0);
    step("preld",   0, 1, 0, 0, 16'h6666, 16'h0002, 1, 1, 0, 16'h6666, 1, 16'h0002, 1, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      step($sformatf("long%0d", i), 0, 1, 1, 0, 16'h7777, 16'h0004,
           1, 0, 1, 16'h6666, 1, 16'h0002, 1, 0, (i >= 5) ? 1'b1 : 1'b0);
    end
`ifdef STALL_STATS_EN
    chk("stall_count", 32'(bus.stall_count), 32'd6);
`endif
    step("postlong",0, 1, 0, 0, 16'h7777, 16'h0004, 1, 1, 0, 16'h7777, 1, 16'h0004, 1, 0, 1);
    step("rststall",1, 1, 1, 0, 16'h7777, 16'h0004, 1, 0, 1, 16'h0800, 1, 16'h0000, 0, 0, 0);
    step("ldhalt2", 0, 1, 0, 0, 16'h0000, 16'h0002, 1, 1, 0, 16'h0000, 1, 16'h0002, 1, 0, 0);
    step("hsquash", 0, 1, 0, 1, 16'h1234, 16'h0004, 1, 1, 1, 16'h0800, 0, 16'h0000, 0, 0, 0);
    step("afterhs", 0, 1, 0, 0, 16'h1234, 16'h0006, 1, 1, 0, 16'h1234, 1, 16'h0006, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
